// File: rtl/rggen_demux_pkg.sv
// Shared status codes and FSM state encodings for the request demultiplexer channel.
package rggen_demux_pkg;

    typedef enum logic [1:0] {
        OK           = 2'b00,
        SELECT_ERROR = 2'b10,
        TIMEOUT      = 2'b11
    } rggen_demux_status;

    localparam int unsigned STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] IDLE     = 2'd0;
    localparam logic [STATE_WIDTH-1:0] REQ      = 2'd1;
    localparam logic [STATE_WIDTH-1:0] WAIT_ACK = 2'd2;
    localparam logic [STATE_WIDTH-1:0] RESP     = 2'd3;

endpackage

// File: rtl/rggen_demux_timer.sv
// Saturating cycle counter that flags the cycle in which the wait budget is used up.
module rggen_demux_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    if (TIMEOUT == 0) begin : g_disabled
        assign expired_c = 1'b0;
    end else begin : g_count
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
        localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

        logic [CW-1:0] count;

        // count holds the number of enabled cycles already completed
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                count <= '0;
            end else if (enable && (count != LIMIT)) begin
                count <= count + CW'(1);
            end
        end

        assign expired_c = enable && (count >= LAST);
    end

endmodule

// File: rtl/rggen_demux_channel.sv
// One-to-N request demultiplexer: forwards one request to a one-hot selected entry
// and returns that entry's acknowledged data (or an error status) upstream.
module rggen_demux_channel #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RESP_WIDTH = 32,
    parameter int unsigned ENTRIES    = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [ENTRIES-1:0]            i_req_select,
    input  logic [WIDTH-1:0]              i_req_data,
    output logic [ENTRIES-1:0]            o_ent_valid,
    input  logic [ENTRIES-1:0]            i_ent_ready,
    output logic [WIDTH-1:0]              o_ent_data,
    input  logic [ENTRIES-1:0]            i_ent_ack,
    input  logic [ENTRIES*RESP_WIDTH-1:0] i_ent_rdata,
    output logic                          o_resp_valid,
    input  logic                          i_resp_ready,
    output logic [1:0]                    o_resp_status,
    output logic [RESP_WIDTH-1:0]         o_resp_data
);

    import rggen_demux_pkg::*;

    logic [STATE_WIDTH-1:0] state_q;
    logic [STATE_WIDTH-1:0] state_d;
    logic [ENTRIES-1:0]     sel_q;
    logic [ENTRIES-1:0]     sel_d;
    logic [WIDTH-1:0]       ent_data_d;
    logic                   req_ready_d;
    logic [ENTRIES-1:0]     ent_valid_d;
    logic                   resp_valid_d;
    rggen_demux_status      status_q;
    rggen_demux_status      status_d;
    logic [RESP_WIDTH-1:0]  resp_data_d;

    logic                   ready_sel;
    logic                   ack_sel;
    logic [RESP_WIDTH-1:0]  rdata_sel;
    logic                   timer_enable;
    logic                   timer_clear;
    logic                   expired_c;

    // Only the captured target's handshake signals are observed.
    assign ready_sel = |(i_ent_ready & sel_q);
    assign ack_sel   = |(i_ent_ack & sel_q);

    always_comb begin : gather
        rdata_sel = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            rdata_sel |= {RESP_WIDTH{sel_q[i]}} & i_ent_rdata[i*RESP_WIDTH +: RESP_WIDTH];
        end
    end

    assign timer_enable = (state_q == REQ) || (state_q == WAIT_ACK);
    assign timer_clear  = !timer_enable;

    rggen_demux_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .expired_c (expired_c)
    );

    // Next-state and next-output logic; an ack always beats a same-cycle expiry.
    always_comb begin : fsm_next
        state_d      = state_q;
        sel_d        = sel_q;
        ent_data_d   = o_ent_data;
        req_ready_d  = o_req_ready;
        ent_valid_d  = o_ent_valid;
        resp_valid_d = o_resp_valid;
        status_d     = status_q;
        resp_data_d  = o_resp_data;

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    sel_d       = i_req_select;
                    ent_data_d  = i_req_data;
                    req_ready_d = 1'b0;
                    if ($onehot(i_req_select)) begin
                        ent_valid_d = i_req_select;
                        state_d     = REQ;
                    end else begin
                        resp_valid_d = 1'b1;
                        status_d     = SELECT_ERROR;
                        resp_data_d  = '0;
                        state_d      = RESP;
                    end
                end
            end
            REQ: begin
                if (ready_sel) begin
                    ent_valid_d = '0;
                    if (ack_sel) begin
                        resp_valid_d = 1'b1;
                        status_d     = OK;
                        resp_data_d  = rdata_sel;
                        state_d      = RESP;
                    end else if (expired_c) begin
                        resp_valid_d = 1'b1;
                        status_d     = rggen_demux_pkg::TIMEOUT;
                        resp_data_d  = '0;
                        state_d      = RESP;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end else if (expired_c) begin
                    ent_valid_d  = '0;
                    resp_valid_d = 1'b1;
                    status_d     = rggen_demux_pkg::TIMEOUT;
                    resp_data_d  = '0;
                    state_d      = RESP;
                end
            end
            WAIT_ACK: begin
                if (ack_sel) begin
                    resp_valid_d = 1'b1;
                    status_d     = OK;
                    resp_data_d  = rdata_sel;
                    state_d      = RESP;
                end else if (expired_c) begin
                    resp_valid_d = 1'b1;
                    status_d     = rggen_demux_pkg::TIMEOUT;
                    resp_data_d  = '0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (i_resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin : fsm_regs
        if (i_rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            o_ent_data   <= '0;
            o_req_ready  <= 1'b1;
            o_ent_valid  <= '0;
            o_resp_valid <= 1'b0;
            status_q     <= OK;
            o_resp_data  <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            o_ent_data   <= ent_data_d;
            o_req_ready  <= req_ready_d;
            o_ent_valid  <= ent_valid_d;
            o_resp_valid <= resp_valid_d;
            status_q     <= status_d;
            o_resp_data  <= resp_data_d;
        end
    end

    assign o_resp_status = status_q;

endmodule

// File: tb/tb_rggen_demux_channel.sv
// Self-checking bench for rggen_demux_channel with four entries and a 16-cycle timeout.
module tb_rggen_demux_channel;

    localparam int TMO = 16;
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_SEL = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    logic         clk;
    logic         rst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [3:0]   i_req_select;
    logic [31:0]  i_req_data;
    logic [3:0]   o_ent_valid;
    logic [3:0]   i_ent_ready;
    logic [31:0]  o_ent_data;
    logic [3:0]   i_ent_ack;
    logic [127:0] i_ent_rdata;
    logic         o_resp_valid;
    logic         i_resp_ready;
    logic [1:0]   o_resp_status;
    logic [31:0]  o_resp_data;

    int checks = 0;
    int errors = 0;

    rggen_demux_channel #(
        .WIDTH      (32),
        .RESP_WIDTH (32),
        .ENTRIES    (4),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_select  (i_req_select),
        .i_req_data    (i_req_data),
        .o_ent_valid   (o_ent_valid),
        .i_ent_ready   (i_ent_ready),
        .o_ent_data    (o_ent_data),
        .i_ent_ack     (i_ent_ack),
        .i_ent_rdata   (i_ent_rdata),
        .o_resp_valid  (o_resp_valid),
        .i_resp_ready  (i_resp_ready),
        .o_resp_status (o_resp_status),
        .o_resp_data   (o_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One transaction. Entry timing: ready[sel] is shown in wait cycle 1+r, ack[sel]
    // r+a... i.e. in wait cycle k=1+r+a. The model: non-one-hot select answers one cycle
    // after accept; otherwise OK if k fits in the TMO budget (cycle k+1), else TIMEOUT at TMO+1.
    task automatic do_txn(input string name, input logic [3:0] sel, input logic [31:0] data,
                          input logic [31:0] rd, input int r, input int a, input int hold,
                          input bit keep_valid, input bit poke3);
        int ones, idx, k, c, exp_lat;
        logic [1:0] exp_st;
        logic [31:0] exp_data;
        logic [3:0] exp_ev;
        bit seen;
        ones = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                ones++;
                idx = i;
            end
        end
        k = 1 + r + a;
        if (ones != 1) begin
            exp_st = ST_SEL; exp_lat = 1; exp_data = '0;
        end else if (k <= TMO) begin
            exp_st = ST_OK; exp_lat = k + 1; exp_data = rd;
        end else begin
            exp_st = ST_TMO; exp_lat = TMO + 1; exp_data = '0;
        end

        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_idle got %b exp 1", name, o_req_ready);
        end
        i_req_valid  = 1'b1;
        i_req_select = sel;
        i_req_data   = data;
        @(posedge clk); #1;
        if (keep_valid) begin
            i_req_select = 4'($urandom);
            i_req_data   = $urandom;
        end else begin
            i_req_valid = 1'b0;
        end
        checks++;
        if (o_ent_data !== data || o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept got data %h ready %b exp data %h ready 0",
                     name, o_ent_data, o_req_ready, data);
        end

        c = 1;
        seen = 1'b0;
        while (!seen && c <= exp_lat + 2) begin
            exp_ev = (ones == 1 && c <= 1 + r && c <= TMO) ? sel : 4'b0000;
            checks++;
            if (o_ent_valid !== exp_ev) begin
                errors++;
                $display("FAIL %s ent_valid cycle %0d got %b exp %b", name, c, o_ent_valid, exp_ev);
            end
            if (o_resp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                i_ent_ready = 4'($urandom) & ~sel;
                i_ent_ack   = 4'($urandom) & ~sel;
                i_ent_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (ones == 1) begin
                    if (c == 1 + r) i_ent_ready = i_ent_ready | sel;
                    if (c == k) begin
                        i_ent_ack = i_ent_ack | sel;
                        i_ent_rdata[idx*32 +: 32] = rd;
                    end
                end
                if (poke3 && c == 2) i_ent_ack[3] = 1'b1;
                @(posedge clk); #1;
                c++;
            end
        end
        i_ent_ready = '0;
        i_ent_ack   = '0;

        checks++;
        if (!seen || c != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d (seen %0d) exp %0d", name, c, seen, exp_lat);
        end
        checks++;
        if (o_resp_status !== exp_st || o_resp_data !== exp_data) begin
            errors++;
            $display("FAIL %s response got %b/%h exp %b/%h", name, o_resp_status, o_resp_data,
                     exp_st, exp_data);
        end

        i_resp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (o_resp_valid !== 1'b1 || o_resp_status !== exp_st || o_resp_data !== exp_data
                || o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold %0d got v%b %b/%h rdy %b exp v1 %b/%h rdy 0", name, h,
                         o_resp_valid, o_resp_status, o_resp_data, o_req_ready, exp_st, exp_data);
            end
        end
        i_resp_ready = 1'b1;
        @(posedge clk); #1;
        i_resp_ready = 1'b0;
        checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake got valid %b ready %b exp 0 1", name,
                     o_resp_valid, o_req_ready);
        end
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        i_req_valid  = 1'b0;
        i_req_select = '0;
        i_req_data   = '0;
        i_ent_ready  = '0;
        i_ent_ack    = '0;
        i_ent_rdata  = '0;
        i_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (o_req_ready !== 1'b1 || o_ent_valid !== 4'b0 || o_ent_data !== 32'h0 ||
            o_resp_valid !== 1'b0 || o_resp_status !== ST_OK || o_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset got rdy %b ev %b ed %h rv %b st %b rd %h exp 1 0 0 0 00 0",
                     o_req_ready, o_ent_valid, o_ent_data, o_resp_valid, o_resp_status, o_resp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_min_latency();
        do_txn("min_latency", 4'b0100, 32'hA5A5_0001, 32'h1234_5678, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_select_error();
        do_txn("sel_zero", 4'b0000, 32'h0000_1111, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 1'b0);
        do_txn("sel_multi", 4'b0011, 32'h0000_2222, 32'hDEAD_BEEF, 0, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn("timeout_wait", 4'b0010, 32'h0000_3333, 32'hCAFE_0001, 0, 100, 0, 1'b0, 1'b0);
        do_txn("timeout_req", 4'b1000, 32'h0000_4444, 32'hCAFE_0002, 40, 0, 0, 1'b0, 1'b0);
        do_txn("ack_at_limit", 4'b0001, 32'h0000_5555, 32'hCAFE_0003, 5, 10, 0, 1'b0, 1'b0);
        do_txn("ack_past_limit", 4'b0001, 32'h0000_6666, 32'hCAFE_0004, 5, 11, 0, 1'b0, 1'b0);
        do_txn("ready_ack_at_limit", 4'b0100, 32'h0000_7777, 32'hCAFE_0005, 15, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_other_ack();
        do_txn("other_ack", 4'b0001, 32'h0000_8888, 32'hBEEF_0000, 0, 3, 0, 1'b0, 1'b1);
    endtask

    task automatic test_resp_hold();
        do_txn("resp_hold", 4'b0010, 32'h0000_9999, 32'h0BAD_F00D, 1, 1, 5, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        i_req_valid  = 1'b1;
        i_req_select = 4'b0010;
        i_req_data   = 32'h7777_0000;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_ent_ready = 4'b0010;
        @(posedge clk); #1;
        i_ent_ready = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (o_req_ready !== 1'b1 || o_ent_valid !== 4'b0 || o_ent_data !== 32'h0 ||
            o_resp_valid !== 1'b0 || o_resp_status !== ST_OK || o_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got rdy %b ev %b ed %h rv %b st %b rd %h exp 1 0 0 0 00 0",
                     o_req_ready, o_ent_valid, o_ent_data, o_resp_valid, o_resp_status, o_resp_data);
        end
        i_ent_ack = 4'b0010;
        i_ent_rdata[63:32] = 32'h5555_AAAA;
        @(posedge clk); #1;
        i_ent_ack = '0;
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_late_ack cycle %0d got valid %b ready %b exp 0 1", n,
                         o_resp_valid, o_req_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] s;
            int r, a, h;
            if ($urandom_range(0, 3) != 0) s = 4'b0001 << $urandom_range(0, 3);
            else s = 4'($urandom);
            r = int'($urandom_range(0, 8));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 6));
            h = int'($urandom_range(0, 3));
            do_txn("random", s, $urandom, $urandom, r, a, h, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_select_error();
        test_timeout();
        test_ignore_other_ack();
        test_resp_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
